coeff_streamer: RTL and testbench

COEFF_STREAMER -- requirements
Module: coeff_streamer

---
 rtl/undistort_pkg.sv | 24 ++
 rtl/coeff_streamer_if.sv | 22 ++
 rtl/coeff_queue.sv | 42 ++++
 rtl/coeff_streamer.sv | 130 +++++++++++++
 tb/tb_coeff_streamer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/undistort_pkg.sv
// Shared constants, FSM encoding and coefficient-set type for the undistortion datapath.
package undistort_pkg;
   localparam int FRAC_W = 5;
   localparam int COEFF_W = 10;
   localparam logic [COEFF_W-1:0] COEFF_MAX = 10'd1023;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [COEFF_W-1:0] tl;
      logic [COEFF_W-1:0] tr;
      logic [COEFF_W-1:0] bl;
      logic [COEFF_W-1:0] br;
   } coeff_set_t;

   // Only (32-0)*(32-0)=1024 can reach bit 10, so clamp that single case.
   function automatic logic [COEFF_W-1:0] sat_coeff(input logic [COEFF_W:0] v);
      return v[COEFF_W] ? COEFF_MAX : v[COEFF_W-1:0];
   endfunction
endpackage

// File: rtl/coeff_streamer_if.sv
// Map-read and coefficient-output bundle: master drives reads/sets, slave serves map data and out_ready.
interface coeff_streamer_if #(parameter int ADDR_W = 19);
   import undistort_pkg::*;
   logic               map_rd_en;
   logic [ADDR_W-1:0]  map_addr;
   logic [9:0]         map_data;
   logic               out_ready;
   logic               out_valid;
   logic [COEFF_W-1:0] coeff_tl;
   logic [COEFF_W-1:0] coeff_tr;
   logic [COEFF_W-1:0] coeff_bl;
   logic [COEFF_W-1:0] coeff_br;

   modport master (
      output map_rd_en, map_addr, out_valid, coeff_tl, coeff_tr, coeff_bl, coeff_br,
      input  map_data, out_ready
   );
   modport slave (
      input  map_rd_en, map_addr, out_valid, coeff_tl, coeff_tr, coeff_bl, coeff_br,
      output map_data, out_ready
   );
endinterface

// File: rtl/coeff_queue.sv
// 4-entry coefficient-set FIFO; head is valid the cycle after push, pop when not empty.
module coeff_queue
   import undistort_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  coeff_set_t push_dat,
   input  logic       pop,
   output coeff_set_t head,
   output logic [2:0] count,
   output logic       full,
   output logic       empty
);
   coeff_set_t mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic       do_push;
   logic       do_pop;

   assign empty   = (count == 3'd0);
   assign full    = (count == 3'd4);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'b0, do_push} - {2'b0, do_pop};
      end
   end
endmodule

// File: rtl/coeff_streamer.sv
// Reads a frame of map entries and emits bilinear weight sets; map_rd_en to out_valid is 3 cycles.
// Backpressure via out_ready into a 4-entry queue; COEFF_STREAMER_PERF_EN adds the stall_cycles counter.
module coeff_streamer
   import undistort_pkg::*;
#(
   parameter int NUM_PIXELS = 307200,
   parameter int ADDR_W     = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   coeff_streamer_if.master  bus,
   output logic              busy,
   output logic              done
`ifdef COEFF_STREAMER_PERF_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] rd_cnt;
   logic [ADDR_W-1:0] map_addr;
   logic              rd_en, d_vld, p_vld;
   coeff_set_t        p_dat, w, head;
   logic [2:0]        q_count;
   logic              q_full, q_empty;
   logic              pop, issue, enter_run, pipe_empty;
   logic [3:0]        pending;
   logic [FRAC_W-1:0] fx, fy;
   logic [FRAC_W:0]   inv_x, inv_y;
   logic [COEFF_W:0]  tl_raw;

   assign pop        = !q_empty && bus.out_ready;
   // Slots committed after this edge, excluding a read issued now.
   assign pending    = {1'b0, q_count} + {3'b0, p_vld} + {3'b0, d_vld} + {3'b0, rd_en} - {3'b0, pop};
   assign pipe_empty = !rd_en && !d_vld && !p_vld && q_empty;
   assign enter_run  = (state == ST_IDLE) && start;
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_RUN;
         ST_RUN: begin
            issue = (pending < 4'd4);
            if (issue && rd_cnt == LAST_ADDR) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: if (pipe_empty) begin
            state_nxt = ST_IDLE;
            done      = 1'b1;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      fx      = bus.map_data[9:5];
      fy      = bus.map_data[4:0];
      inv_x   = 6'd32 - {1'b0, fx};
      inv_y   = 6'd32 - {1'b0, fy};
      tl_raw  = {5'd0, inv_x} * {5'd0, inv_y};
      w       = '0;
      w.tl    = sat_coeff(tl_raw);
      w.tr    = {5'd0, fx} * {4'd0, inv_y};
      w.bl    = {4'd0, inv_x} * {5'd0, fy};
      w.br    = {5'd0, fx} * {5'd0, fy};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_en    <= 1'b0;
         d_vld    <= 1'b0;
         p_vld    <= 1'b0;
         rd_cnt   <= '0;
         map_addr <= '0;
         p_dat    <= '0;
      end else begin
         rd_en <= issue;
         d_vld <= rd_en;
         p_vld <= d_vld;
         if (enter_run) begin
            rd_cnt   <= '0;
            map_addr <= '0;
         end else if (issue) begin
            map_addr <= rd_cnt;
            rd_cnt   <= rd_cnt + ADDR_W'(1);
         end
         if (d_vld) p_dat <= w;
      end
   end

   coeff_queue u_queue (
      .clk      (clk),
      .rst      (rst),
      .push     (p_vld),
      .push_dat (p_dat),
      .pop      (pop),
      .head     (head),
      .count    (q_count),
      .full     (q_full),
      .empty    (q_empty)
   );

   assert property (@(posedge clk) disable iff (rst) !(q_full && p_vld && !pop));

   assign bus.map_rd_en = rd_en;
   assign bus.map_addr  = map_addr;
   assign bus.out_valid = !q_empty;
   assign bus.coeff_tl  = head.tl;
   assign bus.coeff_tr  = head.tr;
   assign bus.coeff_bl  = head.bl;
   assign bus.coeff_br  = head.br;

`ifdef COEFF_STREAMER_PERF_EN
   always_ff @(posedge clk) begin
      if (rst || enter_run) stall_cycles <= '0;
      else if (bus.out_valid && !bus.out_ready && stall_cycles != 32'hFFFF_FFFF)
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif
endmodule

// File: tb/tb_coeff_streamer.sv
// Directed/table-driven bench for coeff_streamer: an 8-pixel and a 20-pixel instance share clk/rst.
module tb_coeff_streamer;
   import undistort_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start8, start20, busy8, busy20, done8, done20, sel, mon_clr;
   coeff_streamer_if #(.ADDR_W(5)) b8 ();
   coeff_streamer_if #(.ADDR_W(5)) b20 ();
`ifdef COEFF_STREAMER_PERF_EN
   logic [31:0] stall8, stall20;
`endif

   coeff_streamer #(.NUM_PIXELS(8), .ADDR_W(5)) u8 (
      .clk(clk), .rst(rst), .start(start8), .bus(b8), .busy(busy8), .done(done8)
`ifdef COEFF_STREAMER_PERF_EN
      , .stall_cycles(stall8)
`endif
   );
   coeff_streamer #(.NUM_PIXELS(20), .ADDR_W(5)) u20 (
      .clk(clk), .rst(rst), .start(start20), .bus(b20), .busy(busy20), .done(done20)
`ifdef COEFF_STREAMER_PERF_EN
      , .stall_cycles(stall20)
`endif
   );

   logic [9:0] map8 [8];
   logic [9:0] map20 [20];
   always @(posedge clk) begin
      if (b8.map_rd_en) b8.map_data <= map8[b8.map_addr[2:0]];
      if (b20.map_rd_en && b20.map_addr < 5'd20) b20.map_data <= map20[b20.map_addr];
   end

   logic m_rd, m_vld, m_rdy, m_done;
   logic [4:0] m_addr;
   coeff_set_t m_set;
   assign m_rd   = sel ? b20.map_rd_en : b8.map_rd_en;
   assign m_addr = sel ? b20.map_addr  : b8.map_addr;
   assign m_vld  = sel ? b20.out_valid : b8.out_valid;
   assign m_rdy  = sel ? b20.out_ready : b8.out_ready;
   assign m_done = sel ? done20 : done8;
   assign m_set  = sel ? {b20.coeff_tl, b20.coeff_tr, b20.coeff_bl, b20.coeff_br}
                       : {b8.coeff_tl, b8.coeff_tr, b8.coeff_bl, b8.coeff_br};

   int cyc, n_rd, n_xfer, first_rd, first_vld, last_xfer, done_cyc, n_done, max_out, addr_bad, hold_bad;
   coeff_set_t got[$];
   coeff_set_t prev_set;
   logic prev_stall;

   always @(negedge clk) begin
      if (mon_clr) begin
         cyc = 0; n_rd = 0; n_xfer = 0; first_rd = -1; first_vld = -1; last_xfer = -1;
         done_cyc = -1; n_done = 0; max_out = 0; addr_bad = 0; hold_bad = 0;
         prev_stall = 1'b0; prev_set = '0; got.delete();
      end else begin
         cyc++;
         if (prev_stall && (!m_vld || m_set != prev_set)) hold_bad++;
         if (m_rd) begin
            if (first_rd < 0) first_rd = cyc;
            if (m_addr != 5'(n_rd)) addr_bad++;
            n_rd++;
         end
         if (n_rd - n_xfer > max_out) max_out = n_rd - n_xfer;
         if (m_vld && first_vld < 0) first_vld = cyc;
         if (m_vld && m_rdy) begin
            got.push_back(m_set);
            n_xfer++;
            last_xfer = cyc;
         end
         if (m_done) begin
            n_done++;
            done_cyc = cyc;
         end
         prev_stall = m_vld && !m_rdy;
         prev_set   = m_set;
      end
   end

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input bit s20);
      if (s20) start20 = 1'b1; else start8 = 1'b1;
      tick();
      start8 = 1'b0;
      start20 = 1'b0;
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
      tick();
   endtask

   task automatic wait_done(input string name, input int budget);
      int k = 0;
      while (!m_done && k < budget) begin tick(); k++; end
      check({name, " done within budget"}, 64'(k < budget), 64'd1);
      tick(2);
   endtask

   function automatic coeff_set_t ref_set(input logic [9:0] m);
      coeff_set_t r;
      int fx, fy, tl;
      fx = int'(m[9:5]);
      fy = int'(m[4:0]);
      tl = (32 - fx) * (32 - fy);
      if (tl > 1023) tl = 1023;
      r.tl = 10'(tl);
      r.tr = 10'(fx * (32 - fy));
      r.bl = 10'((32 - fx) * fy);
      r.br = 10'(fx * fy);
      return r;
   endfunction

   typedef struct {
      logic [4:0] fx, fy;
      logic [9:0] tl, tr, bl, br;
   } vec_t;
   vec_t vt[8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vt[0] = '{5'd0,  5'd0,  10'd1023, 10'd0,   10'd0,   10'd0};
      vt[1] = '{5'd16, 5'd16, 10'd256,  10'd256, 10'd256, 10'd256};
      vt[2] = '{5'd31, 5'd1,  10'd31,   10'd961, 10'd1,   10'd31};
      vt[3] = '{5'd0,  5'd31, 10'd32,   10'd0,   10'd992, 10'd0};
      vt[4] = '{5'd31, 5'd31, 10'd1,    10'd31,  10'd31,  10'd961};
      vt[5] = '{5'd1,  5'd0,  10'd992,  10'd32,  10'd0,   10'd0};
      vt[6] = '{5'd8,  5'd4,  10'd672,  10'd224, 10'd96,  10'd32};
      vt[7] = '{5'd5,  5'd27, 10'd135,  10'd25,  10'd729, 10'd135};

      rst = 1'b1; start8 = 1'b0; start20 = 1'b0; sel = 1'b0; mon_clr = 1'b1;
      b8.out_ready = 1'b0; b20.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) map8[i] = '0;
      for (int i = 0; i < 20; i++) map20[i] = 10'($urandom_range(0, 1023));
      tick(3);

      // Reset state
      check("rst map_rd_en", 64'(b8.map_rd_en), 64'd0);
      check("rst map_addr", 64'(b8.map_addr), 64'd0);
      check("rst out_valid", 64'(b8.out_valid), 64'd0);
      check("rst coeffs", 64'({b8.coeff_tl, b8.coeff_tr, b8.coeff_bl, b8.coeff_br}), 64'd0);
      check("rst busy", 64'(busy8), 64'd0);
      check("rst done", 64'(done8), 64'd0);
      rst = 1'b0;
      tick();

      // All-zero map, free-flowing output: saturation, latency, done timing
      b8.out_ready = 1'b1;
      clear_mon();
      pulse_start(1'b0);
      check("A busy after start", 64'(busy8), 64'd1);
      wait_done("A", 60);
      check("A set count", 64'(n_xfer), 64'd8);
      for (int i = 0; i < 8; i++)
         check($sformatf("A set %0d", i), 64'(i < got.size() ? got[i] : '1),
               64'({10'd1023, 10'd0, 10'd0, 10'd0}));
      check("A read-to-valid latency", 64'(first_vld - first_rd), 64'd3);
      check("A done after last transfer", 64'(done_cyc - last_xfer), 64'd1);
      check("A done pulses", 64'(n_done), 64'd1);
      check("A busy after done", 64'(busy8), 64'd0);

      // Table of hand-computed weight vectors
      for (int i = 0; i < 8; i++) map8[i] = {vt[i].fx, vt[i].fy};
      clear_mon();
      pulse_start(1'b0);
      wait_done("B", 60);
      check("B set count", 64'(n_xfer), 64'd8);
      for (int i = 0; i < 8; i++)
         check($sformatf("B vec %0d", i), 64'(i < got.size() ? got[i] : '1),
               64'({vt[i].tl, vt[i].tr, vt[i].bl, vt[i].br}));
      check("B read order", 64'(addr_bad), 64'd0);

      // Output stalled: reads must stop with four sets outstanding, then random out_ready
      sel = 1'b1;
      clear_mon();
      pulse_start(1'b1);
      tick(15);
      check("C reads while stalled", 64'(n_rd), 64'd4);
      check("C valid while stalled", 64'(b20.out_valid), 64'd1);
      begin
         int k = 0;
         while (!done20 && k < 600) begin
            b20.out_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
         end
         check("C done within budget", 64'(k < 600), 64'd1);
      end
      b20.out_ready = 1'b1;
      tick(2);
      check("C set count", 64'(n_xfer), 64'd20);
      for (int i = 0; i < 20; i++)
         check($sformatf("C set %0d", i), 64'(i < got.size() ? got[i] : '1), 64'(ref_set(map20[i])));
      check("C outstanding within 4", 64'(max_out <= 4), 64'd1);
      check("C hold while stalled", 64'(hold_bad), 64'd0);
      check("C read order", 64'(addr_bad), 64'd0);
      check("C done pulses", 64'(n_done), 64'd1);

      // Reset mid-frame at pixel 5 aborts without done, then a clean restart
      clear_mon();
      pulse_start(1'b1);
      begin
         int k = 0;
         while (!(b20.map_rd_en && b20.map_addr == 5'd5) && k < 40) begin tick(); k++; end
         check("D reached pixel 5", 64'(k < 40), 64'd1);
      end
      rst = 1'b1;
      tick();
      check("D rst map_rd_en", 64'(b20.map_rd_en), 64'd0);
      check("D rst map_addr", 64'(b20.map_addr), 64'd0);
      check("D rst out_valid", 64'(b20.out_valid), 64'd0);
      check("D rst coeffs", 64'({b20.coeff_tl, b20.coeff_tr, b20.coeff_bl, b20.coeff_br}), 64'd0);
      check("D rst busy", 64'(busy20), 64'd0);
      check("D rst done", 64'(done20), 64'd0);
      rst = 1'b0;
      tick(10);
      check("D no done after abort", 64'(n_done), 64'd0);
      clear_mon();
      pulse_start(1'b1);
      wait_done("D restart", 100);
      check("D restart read order", 64'(addr_bad), 64'd0);
      check("D restart reads", 64'(n_rd), 64'd20);
      check("D restart set count", 64'(n_xfer), 64'd20);
      check("D restart first set", 64'(got.size() > 0 ? got[0] : '1), 64'(ref_set(map20[0])));

      // Extra start pulses during RUN and coincident with done are ignored
      sel = 1'b0;
      clear_mon();
      pulse_start(1'b0);
      tick(2);
      pulse_start(1'b0);
      begin
         int k = 0;
         while (!done8 && k < 60) begin tick(); k++; end
         check("E done within budget", 64'(k < 60), 64'd1);
      end
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(20);
      check("E reads", 64'(n_rd), 64'd8);
      check("E set count", 64'(n_xfer), 64'd8);
      check("E done pulses", 64'(n_done), 64'd1);
      check("E idle after frame", 64'(busy8), 64'd0);

`ifdef COEFF_STREAMER_PERF_EN
      // Seven stalled cycles with a valid set pending
      clear_mon();
      pulse_start(1'b0);
      begin
         int k = 0;
         while (!b8.out_valid && k < 20) begin tick(); k++; end
         check("F valid within budget", 64'(k < 20), 64'd1);
      end
      b8.out_ready = 1'b0;
      tick(7);
      b8.out_ready = 1'b1;
      wait_done("F", 60);
      check("F stall_cycles", 64'(stall8), 64'd7);
      check("F set count", 64'(n_xfer), 64'd8);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
